// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix job arbiter: state encoding, widths
// and the size legality rule applied before a job is handed to the engine.
package matrix_pkg;

    localparam int SIZE_W      = 8;
    localparam int ADDR_W      = 5;
    localparam int GRANT_W     = 3;
    localparam int CNT_W       = 16;
    localparam int MAX_DIM_DEF = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_RUN     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // A dimension is usable when it is non-zero and fits the engine's address range.
    function automatic logic size_ok(input logic [SIZE_W-1:0] s, input int max_dim);
        return (s != '0) && (int'(s) <= max_dim);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the search starts one past the last grant and wraps,
// so the most recently served requester has lowest priority.
module rr_arbiter
    import matrix_pkg::*;
#(
    parameter int REQ_COUNT = 4
) (
    input  logic [REQ_COUNT-1:0] i_req,
    input  logic [GRANT_W-1:0]   i_last,
    output logic [REQ_COUNT-1:0] o_grant,
    output logic [GRANT_W-1:0]   o_grant_id,
    output logic                 o_valid
);

    localparam int IW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    int          w_pos;
    logic [IW-1:0] w_idx;

    // Walk the requesters in rotated order and keep the first one found.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_valid    = 1'b0;
        w_pos      = 0;
        w_idx      = '0;
        for (int off = 1; off <= REQ_COUNT; off++) begin
            w_pos = int'(i_last) + off;
            if (w_pos >= REQ_COUNT) begin
                w_pos = w_pos - REQ_COUNT;
            end
            w_idx = IW'(w_pos);
            if (!o_valid && i_req[w_idx]) begin
                o_valid        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_id     = GRANT_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/matrix_job_arbiter.sv
// Shares one matrix engine among REQ_COUNT requesters: round-robin grant,
// size check, supervised run with timeout, and a one-cycle ack/err pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for any request; grant and sizes latched on exit
//   CHECK   | one cycle to validate the latched sizes
//   RUN     | o_start held high; run counter guards against a hung engine
//   RELEASE | o_start low; wait for the engine to report idle again
//   ACK     | one-cycle ack (and err) to the granted requester
module matrix_job_arbiter
    import matrix_pkg::*;
#(
    parameter int REQ_COUNT      = 4,
    parameter int MAX_DIM        = MAX_DIM_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        CLOCK_25,
    input  logic                        rst,
    input  logic [REQ_COUNT-1:0]        i_req,
    input  logic [SIZE_W*REQ_COUNT-1:0] i_size_row,
    input  logic [SIZE_W*REQ_COUNT-1:0] i_size_column,
    output logic [REQ_COUNT-1:0]        o_ack,
    output logic [REQ_COUNT-1:0]        o_err,
    output logic                        o_start,
    output logic [SIZE_W-1:0]           o_size_row,
    output logic [SIZE_W-1:0]           o_size_column,
    input  logic                        i_finished,
    output logic                        o_busy,
    output logic [GRANT_W-1:0]          o_grant_id,
    output logic [CNT_W-1:0]            o_job_count
);

    localparam logic [CNT_W-1:0] LP_RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [GRANT_W-1:0]   r_grant_id;
    logic [GRANT_W-1:0]   r_last;
    logic [SIZE_W-1:0]    r_size_row;
    logic [SIZE_W-1:0]    r_size_col;
    logic [CNT_W-1:0]     r_job_count;
    logic [CNT_W-1:0]     r_run_cnt;
    logic                 r_err;

    logic [REQ_COUNT-1:0] w_gnt_oh;
    logic [GRANT_W-1:0]   w_gnt_id;
    logic                 w_any_req;
    logic [SIZE_W-1:0]    w_sel_row;
    logic [SIZE_W-1:0]    w_sel_col;
    logic                 w_size_bad;
    logic                 w_timeout;

    rr_arbiter #(
        .REQ_COUNT (REQ_COUNT)
    ) u_rr (
        .i_req      (i_req),
        .i_last     (r_last),
        .o_grant    (w_gnt_oh),
        .o_grant_id (w_gnt_id),
        .o_valid    (w_any_req)
    );

    // Route the granted requester's size slices toward the latch.
    always_comb begin
        w_sel_row = '0;
        w_sel_col = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            if (w_gnt_oh[k]) begin
                w_sel_row = i_size_row[SIZE_W*k +: SIZE_W];
                w_sel_col = i_size_column[SIZE_W*k +: SIZE_W];
            end
        end
    end

    assign w_size_bad = !size_ok(r_size_row, MAX_DIM) || !size_ok(r_size_col, MAX_DIM);
    assign w_timeout  = (r_run_cnt == LP_RUN_LAST);

    // State register.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and state-decoded outputs; engine-done takes priority over timeout.
    always_comb begin
        w_next  = r_state;
        o_start = 1'b0;
        o_busy  = (r_state != ST_IDLE);
        o_ack   = '0;
        o_err   = '0;
        unique case (r_state)
            ST_IDLE:    if (w_any_req) w_next = ST_CHECK;
            ST_CHECK:   w_next = w_size_bad ? ST_ACK : ST_RUN;
            ST_RUN: begin
                o_start = 1'b1;
                if (!i_finished || w_timeout) w_next = ST_RELEASE;
            end
            ST_RELEASE: if (i_finished) w_next = ST_ACK;
            ST_ACK: begin
                w_next = ST_IDLE;
                for (int k = 0; k < REQ_COUNT; k++) begin
                    if (r_grant_id == GRANT_W'(k)) begin
                        o_ack[k] = 1'b1;
                        o_err[k] = r_err;
                    end
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Job context: grant/sizes latched at grant time, run counter, error and completion count.
    always_ff @(posedge CLOCK_25) begin
        if (rst) begin
            r_grant_id  <= '0;
            r_last      <= GRANT_W'(REQ_COUNT - 1);
            r_size_row  <= '0;
            r_size_col  <= '0;
            r_job_count <= '0;
            r_run_cnt   <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_gnt_id;
                        r_size_row <= w_sel_row;
                        r_size_col <= w_sel_col;
                    end
                end
                ST_CHECK: begin
                    r_run_cnt <= '0;
                    if (w_size_bad) r_err <= 1'b1;
                end
                ST_RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    if (i_finished && w_timeout) r_err <= 1'b1;
                end
                ST_ACK: begin
                    r_last <= r_grant_id;
                    r_err  <= 1'b0;
                    if (!r_err && (r_job_count != {CNT_W{1'b1}})) begin
                        r_job_count <= r_job_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_grant_id    = r_grant_id;
    assign o_size_row    = r_size_row;
    assign o_size_column = r_size_col;
    assign o_job_count   = r_job_count;

endmodule

// File: doc/matrix_job_arbiter.md
MATRIX_JOB_ARBITER -- requirements
Module: matrix_job_arbiter

Interface
REQ-001 Parameter REQ_COUNT, default 4, number of requesters sharing one matrix engine (2..8).
REQ-002 Parameter MAX_DIM, default 32, largest legal size_row/size_column; the engine's addresses are 5 bits wide.
REQ-003 Parameter TIMEOUT_CYCLES, default 65535, maximum cycles a job may run before it is aborted.
REQ-004 CLOCK_25  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req  in  REQ_COUNT  per-requester job request, level; held until that requester's ack.
REQ-007 i_size_row  in  8*REQ_COUNT  packed rows per requester; slice k = bits [8k+7:8k].
REQ-008 i_size_column  in  8*REQ_COUNT  packed columns per requester; same slicing as REQ-007.
REQ-009 o_ack  out  REQ_COUNT  one-cycle completion pulse to the granted requester.
REQ-010 o_err  out  REQ_COUNT  asserted together with o_ack when the job was rejected or aborted.
REQ-011 o_start  out  1  engine start level.
REQ-012 o_size_row / o_size_column  out  8 each  sizes latched for the engine.
REQ-013 i_finished  in  1  engine finished flag (protocol in REQ-019).
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_grant_id  out  3  index of the current or most recent grant.
REQ-016 o_job_count  out  16  count of successfully completed jobs; saturates at 0xFFFF.

Function
REQ-017 States: IDLE, CHECK, RUN, RELEASE, ACK; the FSM is registered with a single next-state process.
REQ-018 Arbitration: in IDLE with any i_req set, round-robin grant starting from the index after the last grant.
  - At the same edge: latch o_grant_id, o_size_row and o_size_column from the granted slice; go to CHECK.
REQ-019 Engine protocol:
  - The arbiter holds o_start=1 for the whole job.
  - The engine signals done by driving i_finished=0.
  - The arbiter then drops o_start; the engine is back at idle when i_finished returns to 1.
REQ-020 CHECK (1 cycle):
  - Either latched size ==0 or >MAX_DIM: go to ACK with error set.
  - Otherwise: go to RUN with o_start=1 from the next edge.
  - Latency from i_req rising in IDLE to o_start high is exactly 2 cycles.
REQ-021 RUN: o_start=1; a 16-bit run counter increments each cycle.
  - i_finished==0: go to RELEASE.
  - Counter reaches TIMEOUT_CYCLES-1 first: go to RELEASE with error set.
REQ-022 RELEASE: o_start=0; stay until i_finished==1, then go to ACK.
REQ-023 ACK (1 cycle):
  - o_ack[grant]=1 and o_err[grant]=error flag.
  - If no error, o_job_count increments unless it is at 0xFFFF.
  - Last-grant pointer is set to the grant; go to IDLE; error flag clears.
REQ-024 Sizes and grant are frozen from CHECK through ACK; requester input changes during a job are ignored.
REQ-025 A requester deasserting i_req mid-job does not abort the job; ack is still issued.
REQ-026 Same-cycle requests: exactly one grant per job.
  - Round-robin guarantees every continuously requesting requester a grant within REQ_COUNT jobs.
REQ-027 Pointer wrap: the index after REQ_COUNT-1 is 0.
REQ-028 A requester's i_req still high in the IDLE cycle after its ack counts as a new request.
REQ-029 o_ack and o_err are zero for all non-granted indices at all times.

Reset
REQ-030 On rst the outputs take these values at the next edge:
  - state=IDLE, o_start=0, o_ack=0, o_err=0, o_busy=0.
  - o_grant_id=0, last-grant pointer=REQ_COUNT-1 (so requester 0 has first priority).
  - o_size_row=0, o_size_column=0, o_job_count=0, run counter=0, error flag=0.
REQ-031 Reset mid-job:
  - o_start drops within one edge and no ack is issued for the aborted job.
  - The engine is allowed to finish its current pass unsupervised.
  - After reset the arbiter waits in IDLE as usual; software re-issues the job.

Structure
REQ-032 Shared package matrix_pkg holds:
  - state encoding constants (IDLE=0, CHECK=1, RUN=2, RELEASE=3, ACK=4; 3-bit);
  - MAX_DIM default, the size width (8) and the address width (5).
REQ-033 One sub-module, rr_arbiter: request vector plus last-grant pointer in, one-hot grant and encoded index out, purely combinational.

Verification
REQ-034 Single job:
  - Stimulus: req[0] with 4x4; engine model drops i_finished 20 cycles after start and raises it 2 cycles after start falls.
  - Required: o_start high 2 cycles after req; ack[0] pulse with err=0; o_job_count=1.
REQ-035 Round-robin: req[3:0]=1111 held continuously -> grant order 0,1,2,3,0 and each ack goes to the matching index.
REQ-036 Invalid size:
  - req[2] with size_row=0 -> ack[2] and err[2] in the 3rd cycle; o_start never rises.
  - Repeat with size_column=33 -> same response.
REQ-037 Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, engine never drops i_finished.
  - Required: o_start falls after 16 RUN cycles; ack and err pulse for the granted requester; o_job_count unchanged.
REQ-038 Reset mid-RUN: rst asserted at cycle 10 of a job -> o_start=0 and o_busy=0 next edge, no ack, o_job_count=0.
REQ-039 Saturation: preload 0xFFFE, run 3 jobs -> o_job_count=0xFFFF.
